matmul_job_sched: RTL and testbench
===================================

// Module: matmul_job_sched
// PURPOSE
//  Round-robin scheduler sharing one matmul accelerator among NREQ requesters.
//  Grants one job at a time and issues one APB master write of the job's control word to CTRL_ADDR.
//  It then waits for the accelerator busy flag to drop and returns a done pulse with status.
//  Sits between requester engines and the matmul APB slave port (psel/penable/.../busy).
// PARAMETERS
//  NREQ        2       number of requesters (2..8)
//  DATA_WIDTH  16      element width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam)
//  BUS_WIDTH   64      APB data width
//  ADDR_WIDTH  16      APB address width
//  CTRL_ADDR   16'h0   accelerator control register address
//  SETTLE_CYC  2       cycles ignored after write completes before busy_i is trusted (>=1)
//  TIMEOUT_CYC 4096    busy watchdog limit (used only with MATMUL_SCHED_TIMEOUT_EN)
// PORTS
//  clk_i      in   1                 clock; one clock domain
//  rst_i      in   1                 reset, asynchronous, active-high
//  req_i      in   NREQ              job request; held until matching done_o
//  ctrl_i     in   NREQ*BUS_WIDTH    per-requester control word, slice r = [r*BUS_WIDTH +: BUS_WIDTH]
//  gnt_o      out  NREQ              one-hot; high from grant until done
//  done_o     out  NREQ              one-cycle completion pulse to the granted requester
//  err_o      out  2                 status, valid with done_o: 00 ok, 01 pslverr, 10 timeout
//  psel_o     out  1                 APB select
//  penable_o  out  1                 APB enable
//  pwrite_o   out  1                 APB write; always 1 during a transfer
//  pstrb_o    out  MAX_DIM           APB strobe; all ones during a transfer
//  pwdata_o   out  BUS_WIDTH         ctrl word latched at grant
//  paddr_o    out  ADDR_WIDTH        CTRL_ADDR during a transfer
//  pready_i   in   1                 APB ready
//  pslverr_i  in   1                 APB error, sampled with pready_i
//  busy_i     in   1                 accelerator busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, round-robin pointer = 0. Async assert aborts any transfer.
//   The abort drops psel_o immediately and sends no done_o.
//  States: IDLE -> SETUP -> ACCESS -> SETTLE -> WAIT_BUSY -> DONE -> IDLE.
//  IDLE: when any req_i is set and busy_i==0, grant the first requester at or after the pointer (wrapping).
//   Set gnt_o, latch ctrl_i slice into pwdata_o, go to SETUP.
//   If busy_i==1, no grant is made (external user owns the accelerator).
//  SETUP: psel_o=1, penable_o=0, addr/data/strb/pwrite valid. Always one cycle.
//  ACCESS: psel_o=1, penable_o=1. Hold until pready_i==1; zero wait states is legal.
//   On pready_i, APB outputs are cleared next cycle.
//   pslverr_i=1 -> err=01, go to DONE (skip busy wait); else go to SETTLE.
//  SETTLE: count SETTLE_CYC cycles, ignore busy_i, then WAIT_BUSY.
//  WAIT_BUSY: leave when busy_i==0 (checked every cycle).
//  DONE: done_o[g]=1 for one cycle with err_o. gnt_o and err_o clear on the next cycle.
//   Pointer = g+1 mod NREQ. Return to IDLE; the earliest new grant is the cycle after DONE.
//  req_i dropped mid-job is ignored; the job completes and done_o still pulses.
//  Simultaneous requests: strict round robin. After g, the next grant goes to lowest r>g, wrapping.
//  ctrl_i changes after grant have no effect; pwdata_o is stable for the whole transfer.
//  Worst-case latency with no wait states and busy already low: grant-to-done = 1+1+SETTLE_CYC+1+1 cycles.
// CONFIGURATION
//  MATMUL_SCHED_TIMEOUT_EN defined:
//   16-bit counter runs in WAIT_BUSY. When it reaches TIMEOUT_CYC with busy_i still 1: err=10, go to DONE.
//   The counter clears on entry to WAIT_BUSY.
//  Not defined: no counter; WAIT_BUSY waits indefinitely; err_o is never 10.
// STRUCTURE
//  Package matmul_sched_pkg holds:
//   state enum (IDLE, SETUP, ACCESS, SETTLE, WAIT_BUSY, DONE)
//   err codes (ERR_OK=2'b00, ERR_SLV=2'b01, ERR_TMO=2'b10)
//  Sub-module rr_arbiter (NREQ): inputs req, pointer; output one-hot grant. Purely combinational.
//  FSM, counters and APB registers live in matmul_job_sched.
// TESTING
//  1. Single job: req_i=01, ctrl_i[0]=64'h1, pready_i=1, busy_i 1 for 5 cycles after SETTLE.
//     -> one APB write (addr 0, data 1, pstrb 4'hF); done_o=01 with err_o=00.
//  2. Contention: req_i=11 held. -> grants alternate 01,10,01. Each done_o pulses once per job.
//     No overlap of psel_o between jobs.
//  3. Wait states: pready_i low for 3 ACCESS cycles.
//     -> psel/penable/pwdata stable all 3 cycles; transfer completes on the 4th.
//  4. Slave error: pslverr_i=1 with pready_i. -> done_o next cycle with err_o=01; no busy wait.
//  5. Reset during ACCESS: assert rst_i. -> psel_o, gnt_o and done_o 0 asynchronously.
//     After release, a pending req_i=01 is re-granted from IDLE.
//  6. With MATMUL_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, busy_i stuck 1.
//     -> done_o 16 cycles after WAIT_BUSY entry, err_o=10.
//     Without the macro: no done_o for 1000 cycles.

Source files
------------

// File: rtl/matmul_sched_pkg.sv
// rtl/matmul_sched_pkg.sv - shared state encoding and status codes for the matmul job scheduler
package matmul_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        ACCESS    = 3'd2,
        SETTLE    = 3'd3,
        WAIT_BUSY = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_SLV = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;

    // scan from the pointer upward, wrapping, and take the first active request
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                gnt[(int'(ptr) + i) % NREQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_job_sched.sv
// rtl/matmul_job_sched.sv - round-robin job scheduler driving one APB write per job; optional busy watchdog via MATMUL_SCHED_TIMEOUT_EN
module matmul_job_sched
    import matmul_sched_pkg::*;
#(
    parameter int                  NREQ        = 2,
    parameter int                  DATA_WIDTH  = 16,
    parameter int                  BUS_WIDTH   = 64,
    parameter int                  ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR = '0,
    parameter int                  SETTLE_CYC  = 2,
    parameter int                  TIMEOUT_CYC = 4096
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ*BUS_WIDTH-1:0]     ctrl_i,
    output logic [NREQ-1:0]               gnt_o,
    output logic [NREQ-1:0]               done_o,
    output logic [1:0]                    err_o,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
    output logic [BUS_WIDTH-1:0]          pwdata_o,
    output logic [ADDR_WIDTH-1:0]         paddr_o,
    input  logic                          pready_i,
    input  logic                          pslverr_i,
    input  logic                          busy_i
);

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int PW      = $clog2(NREQ);

    state_t                state;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         gnt_idx;
    logic [NREQ-1:0]       arb_gnt;
    logic [PW-1:0]         arb_idx;
    logic [BUS_WIDTH-1:0]  arb_ctrl;
    logic [PW-1:0]         next_ptr;
    logic [15:0]           settle_cnt;
`ifdef MATMUL_SCHED_TIMEOUT_EN
    logic [15:0]           tmo_cnt;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req (req_i),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // index and control word of the requester the arbiter is offering this cycle
    always_comb begin
        arb_idx  = '0;
        arb_ctrl = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (arb_gnt[r]) begin
                arb_idx  = PW'(r);
                arb_ctrl = ctrl_i[r*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // pointer moves to the requester just after the one being completed
    always_comb begin
        next_ptr = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // job sequencer: grant, APB write, settle, busy wait, completion pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            gnt_o      <= '0;
            done_o     <= '0;
            err_o      <= ERR_OK;
            psel_o     <= 1'b0;
            penable_o  <= 1'b0;
            pwrite_o   <= 1'b0;
            pstrb_o    <= '0;
            pwdata_o   <= '0;
            paddr_o    <= '0;
            settle_cnt <= '0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            done_o <= '0;
            case (state)
                IDLE: begin
                    if ((|req_i) && !busy_i) begin
                        gnt_o    <= arb_gnt;
                        gnt_idx  <= arb_idx;
                        pwdata_o <= arb_ctrl;
                        psel_o   <= 1'b1;
                        pwrite_o <= 1'b1;
                        pstrb_o  <= {MAX_DIM{1'b1}};
                        paddr_o  <= CTRL_ADDR;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        pwrite_o  <= 1'b0;
                        pstrb_o   <= '0;
                        pwdata_o  <= '0;
                        paddr_o   <= '0;
                        if (pslverr_i) begin
                            err_o  <= ERR_SLV;
                            done_o <= gnt_o;
                            state  <= DONE;
                        end else begin
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 16'(SETTLE_CYC - 1)) begin
`ifdef MATMUL_SCHED_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        state   <= WAIT_BUSY;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                WAIT_BUSY: begin
                    if (!busy_i) begin
                        err_o  <= ERR_OK;
                        done_o <= gnt_o;
                        state  <= DONE;
                    end
`ifdef MATMUL_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        err_o  <= ERR_TMO;
                        done_o <= gnt_o;
                        state  <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    gnt_o <= '0;
                    err_o <= ERR_OK;
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_job_sched.sv
// tb/tb_matmul_job_sched.sv - randomized self-checking bench for matmul_job_sched with a round-robin job model
module tb_matmul_job_sched;
    import matmul_sched_pkg::*;

    localparam int NREQ = 3;
    localparam int BW   = 64;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int MD   = BW / DW;
    localparam int S    = 2;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*BW-1:0] ctrl_i;
    logic [NREQ-1:0]   gnt_o;
    logic [NREQ-1:0]   done_o;
    logic [1:0]        err_o;
    logic              psel_o, penable_o, pwrite_o;
    logic [MD-1:0]     pstrb_o;
    logic [BW-1:0]     pwdata_o;
    logic [AW-1:0]     paddr_o;
    logic              pready_i, pslverr_i, busy_i;

    matmul_job_sched #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW),
        .CTRL_ADDR(16'h0), .SETTLE_CYC(S), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .ctrl_i(ctrl_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pstrb_o(pstrb_o), .pwdata_o(pwdata_o), .paddr_o(paddr_o),
        .pready_i(pready_i), .pslverr_i(pslverr_i), .busy_i(busy_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    // observations of one job, filled by run_job
    logic [NREQ-1:0] obs_gnt, obs_done;
    logic [1:0]      obs_err;
    logic [BW-1:0]   obs_data;
    logic [AW-1:0]   obs_addr;
    logic [MD-1:0]   obs_strb;
    logic            obs_pwrite;
    int              obs_len, obs_done_cnt, obs_setups;
    bit              obs_stable, obs_finished;

    function automatic int pick(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++)
            if (r[(model_ptr + i) % NREQ]) return (model_ptr + i) % NREQ;
        return 0;
    endfunction

    function automatic logic [BW-1:0] word_of(input int r);
        logic [NREQ*BW-1:0] c;
        c = ctrl_i;
        return c[r*BW +: BW];
    endfunction

    task automatic randomize_ctrl();
        for (int r = 0; r < NREQ; r++) ctrl_i[r*BW +: BW] = {$urandom, $urandom};
    endtask

    // acts as APB slave and accelerator for one job; called at a negedge with req_i already set
    task automatic run_job(input int ws, input bit serr, input int bcyc);
        int  ws_cnt = 0;
        int  bcnt = 0;
        bit  after = 0;
        obs_gnt = '0; obs_done = '0; obs_err = '0; obs_data = '0; obs_addr = '0;
        obs_strb = '0; obs_pwrite = 0; obs_len = 0; obs_done_cnt = 0; obs_setups = 0;
        obs_stable = 1; obs_finished = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            pready_i = 0; pslverr_i = 0;
            if (after) begin
                busy_i = (bcnt < S + bcyc);
                bcnt++;
            end
            if (gnt_o != 0) begin
                obs_len++;
                if (obs_gnt == 0) obs_gnt = gnt_o;
            end
            if (done_o != 0) begin
                obs_done_cnt++; obs_done = done_o; obs_err = err_o;
            end
            if (psel_o && !penable_o) begin
                obs_setups++; obs_addr = paddr_o; obs_data = pwdata_o;
                obs_strb = pstrb_o; obs_pwrite = pwrite_o;
            end
            if (psel_o && penable_o) begin
                if (paddr_o !== obs_addr || pwdata_o !== obs_data ||
                    pstrb_o !== obs_strb || pwrite_o !== obs_pwrite) obs_stable = 0;
                if (ws_cnt < ws) ws_cnt++;
                else begin pready_i = 1; pslverr_i = serr; after = 1; end
            end
            if (obs_gnt != 0 && gnt_o == 0) begin obs_finished = 1; break; end
            if (obs_gnt != 0) randomize_ctrl();
        end
        busy_i = 0; pready_i = 0; pslverr_i = 0;
        if (obs_gnt != 0) model_ptr = ($clog2(int'(obs_gnt)) + 1) % NREQ;
    endtask

    task automatic test_reset();
        rst = 1; req_i = '0; ctrl_i = '0; pready_i = 0; pslverr_i = 0; busy_i = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({psel_o, penable_o, pwrite_o, pstrb_o, paddr_o, pwdata_o} !== '0) begin
            errors++; $display("FAIL reset_apb: got psel=%b pen=%b data=%h expected all 0", psel_o, penable_o, pwdata_o);
        end
        checks++;
        if ({gnt_o, done_o, err_o} !== '0) begin
            errors++; $display("FAIL reset_status: got gnt=%b done=%b err=%b expected 0", gnt_o, done_o, err_o);
        end
        rst = 0; model_ptr = 0;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] exp_oh;
        ctrl_i = '0; ctrl_i[63:0] = 64'h1; req_i = 3'b001;
        exp_oh = NREQ'(1) << pick(req_i);
        run_job(0, 0, 5);
        req_i = '0;
        checks++;
        if (obs_gnt !== exp_oh || obs_done !== exp_oh) begin
            errors++; $display("FAIL single_gnt_done: got gnt=%b done=%b expected %b", obs_gnt, obs_done, exp_oh);
        end
        checks++;
        if (obs_addr !== 16'h0 || obs_data !== 64'h1 || obs_strb !== 4'hF || obs_pwrite !== 1'b1) begin
            errors++; $display("FAIL single_apb: got addr=%h data=%h strb=%h pwrite=%b expected 0/1/F/1", obs_addr, obs_data, obs_strb, obs_pwrite);
        end
        checks++;
        if (obs_err !== ERR_OK || obs_done_cnt !== 1 || obs_setups !== 1) begin
            errors++; $display("FAIL single_status: got err=%b dones=%0d setups=%0d expected 00/1/1", obs_err, obs_done_cnt, obs_setups);
        end
        checks++;
        if (obs_len !== S + 4 + 5) begin
            errors++; $display("FAIL single_len: got %0d expected %0d", obs_len, S + 9);
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_oh, prev;
        logic [BW-1:0]   exp_data;
        prev = '0;
        for (int j = 0; j < 4; j++) begin
            randomize_ctrl();
            req_i = 3'b011;
            exp_oh = NREQ'(1) << pick(req_i);
            exp_data = word_of(pick(req_i));
            run_job(0, 0, $urandom_range(0, 2));
            checks++;
            if (obs_gnt !== exp_oh || obs_gnt === prev) begin
                errors++; $display("FAIL contention_gnt%0d: got %b expected %b", j, obs_gnt, exp_oh);
            end
            checks++;
            if (obs_data !== exp_data || obs_done_cnt !== 1 || obs_setups !== 1) begin
                errors++; $display("FAIL contention_job%0d: got data=%h dones=%0d setups=%0d expected %h/1/1", j, obs_data, obs_done_cnt, obs_setups, exp_data);
            end
            prev = obs_gnt;
        end
        req_i = '0;
    endtask

    task automatic test_wait_states();
        logic [BW-1:0] exp_data;
        randomize_ctrl();
        req_i = 3'b100;
        exp_data = word_of(pick(req_i));
        run_job(3, 0, 0);
        req_i = '0;
        checks++;
        if (obs_stable !== 1'b1 || obs_data !== exp_data) begin
            errors++; $display("FAIL wait_stable: got stable=%b data=%h expected 1/%h", obs_stable, obs_data, exp_data);
        end
        checks++;
        if (obs_len !== S + 4 + 3 || obs_err !== ERR_OK) begin
            errors++; $display("FAIL wait_len: got len=%0d err=%b expected %0d/00", obs_len, obs_err, S + 7);
        end
    endtask

    task automatic test_slave_error();
        req_i = 3'b010;
        run_job(0, 1, 3);
        req_i = '0;
        checks++;
        if (obs_err !== ERR_SLV || obs_done_cnt !== 1) begin
            errors++; $display("FAIL slverr_status: got err=%b dones=%0d expected 01/1", obs_err, obs_done_cnt);
        end
        checks++;
        if (obs_len !== 3) begin
            errors++; $display("FAIL slverr_len: got %0d expected 3", obs_len);
        end
    endtask

    task automatic test_busy_block();
        int seen = 0;
        req_i = 3'b001; busy_i = 1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (gnt_o != 0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL busy_block: got %0d granted cycles expected 0", seen);
        end
        busy_i = 0;
        run_job(0, 0, 0);
        req_i = '0;
        checks++;
        if (obs_gnt !== 3'b001 || obs_done_cnt !== 1) begin
            errors++; $display("FAIL busy_release: got gnt=%b dones=%0d expected 001/1", obs_gnt, obs_done_cnt);
        end
    endtask

    task automatic test_reset_abort();
        bit reached = 0;
        req_i = 3'b001; pready_i = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (psel_o && penable_o) begin reached = 1; break; end
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL abort_access: got no ACCESS phase expected one within 10 cycles");
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({psel_o, penable_o, gnt_o, done_o} !== '0) begin
            errors++; $display("FAIL abort_async: got psel=%b pen=%b gnt=%b done=%b expected 0", psel_o, penable_o, gnt_o, done_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== '0) begin
            errors++; $display("FAIL abort_nodone: got %b expected 0", done_o);
        end
        rst = 0; model_ptr = 0;
        run_job(0, 0, 1);
        req_i = '0;
        checks++;
        if (obs_gnt !== 3'b001 || obs_done !== 3'b001 || obs_err !== ERR_OK) begin
            errors++; $display("FAIL abort_regrant: got gnt=%b done=%b err=%b expected 001/001/00", obs_gnt, obs_done, obs_err);
        end
    endtask

    task automatic test_busy_stuck();
        bit xfer = 0;
        int done_k = -1;
        logic [1:0] derr = '0;
        logic [NREQ-1:0] exp_oh, dseen;
        req_i = 3'b110;
        exp_oh = NREQ'(1) << pick(req_i);
        dseen = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            pready_i = 0;
            if (psel_o && penable_o) begin pready_i = 1; xfer = 1; break; end
        end
        checks++;
        if (!xfer) begin
            errors++; $display("FAIL stuck_xfer: got no transfer expected one within 20 cycles");
        end
`ifdef MATMUL_SCHED_TIMEOUT_EN
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            pready_i = 0; busy_i = 1;
            if (done_o != 0) begin done_k = k; derr = err_o; dseen = done_o; break; end
        end
        checks++;
        if (done_k !== S + TMO || derr !== ERR_TMO || dseen !== exp_oh) begin
            errors++; $display("FAIL stuck_timeout: got at=%0d err=%b done=%b expected %0d/10/%b", done_k, derr, dseen, S + TMO, exp_oh);
        end
`else
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            pready_i = 0; busy_i = 1;
            if (done_o != 0) begin done_k = k; break; end
        end
        checks++;
        if (done_k !== -1) begin
            errors++; $display("FAIL stuck_wait: got done at %0d expected none in 1000 cycles", done_k);
        end
        busy_i = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done_o != 0) begin done_k = k; derr = err_o; dseen = done_o; break; end
        end
        checks++;
        if (done_k !== 0 || derr !== ERR_OK || dseen !== exp_oh) begin
            errors++; $display("FAIL stuck_release: got at=%0d err=%b done=%b expected 0/00/%b", done_k, derr, dseen, exp_oh);
        end
`endif
        busy_i = 0;
        for (int n = 0; n < 5 && gnt_o != 0; n++) @(negedge clk);
        model_ptr = (pick(req_i) + 1) % NREQ;
        req_i = '0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] exp_oh;
        logic [BW-1:0]   exp_data;
        int ws, bcyc, exp_len;
        bit serr;
        for (int j = 0; j < 20; j++) begin
            randomize_ctrl();
            req_i = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ws = $urandom_range(0, 3);
            serr = ($urandom_range(0, 3) == 0);
            bcyc = $urandom_range(0, 4);
            exp_oh = NREQ'(1) << pick(req_i);
            exp_data = word_of(pick(req_i));
            exp_len = serr ? 3 + ws : S + 4 + ws + bcyc;
            run_job(ws, serr, bcyc);
            checks++;
            if (!obs_finished || obs_gnt !== exp_oh || obs_done !== exp_oh) begin
                errors++; $display("FAIL rand%0d_gnt: got gnt=%b done=%b fin=%b expected %b", j, obs_gnt, obs_done, obs_finished, exp_oh);
            end
            checks++;
            if (obs_data !== exp_data || obs_stable !== 1'b1 || obs_setups !== 1) begin
                errors++; $display("FAIL rand%0d_apb: got data=%h stable=%b setups=%0d expected %h/1/1", j, obs_data, obs_stable, obs_setups, exp_data);
            end
            checks++;
            if (obs_err !== (serr ? ERR_SLV : ERR_OK) || obs_done_cnt !== 1 || obs_len !== exp_len) begin
                errors++; $display("FAIL rand%0d_status: got err=%b dones=%0d len=%0d expected %b/1/%0d", j, obs_err, obs_done_cnt, obs_len, serr ? ERR_SLV : ERR_OK, exp_len);
            end
            if ($urandom_range(0, 1) == 1) req_i = '0;
        end
        req_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wait_states();
        test_slave_error();
        test_busy_block();
        test_reset_abort();
        test_busy_stuck();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
